// File: rtl/ifu_fetch_pkg.sv
// Shared core defines for the instruction fetch unit: widths, reset PC,
// fetch FSM encoding and the fetch-queue entry layout.
package ifu_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ins;
    logic            taken;
  } fq_entry_t;

  localparam int unsigned FQ_ENTRY_W = $bits(fq_entry_t);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: branch predictor, redirect/stall control,
// instruction memory and decode handshake.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic [XLEN-1:0] bp_pc_o;
  logic            bp_stall_o;
  logic [XLEN-1:0] bp_next_pc_i;
  logic            bp_next_taken_i;

  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            stall_i;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [ILEN-1:0] imem_rdata_i;

  logic            id_valid_o;
  logic [XLEN-1:0] id_pc_o;
  logic [ILEN-1:0] id_ins_o;
  logic            id_pred_taken_o;
  logic            id_ready_i;

  modport master (
    output bp_pc_o, bp_stall_o, imem_req_o, imem_addr_o,
           id_valid_o, id_pc_o, id_ins_o, id_pred_taken_o,
    input  bp_next_pc_i, bp_next_taken_i, redirect_i, redirect_pc_i, stall_i,
           imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

  modport slave (
    input  bp_pc_o, bp_stall_o, imem_req_o, imem_addr_o,
           id_valid_o, id_pc_o, id_ins_o, id_pred_taken_o,
    output bp_next_pc_i, bp_next_taken_i, redirect_i, redirect_pc_i, stall_i,
           imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// Fetch queue: power-of-two circular buffer with synchronous clear.
// The head is presented combinationally and forced to zero when empty.
module ifu_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65
) (
  input  logic             ck_i,
  input  logic             rs_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_data_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_en;
  logic             pop_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i & ~full_o & ~clear_i;
  assign pop_en  = pop_i & ~empty_o & ~clear_i;

  assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge ck_i or posedge rs_i) begin
    if (rs_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge ck_i) begin
      if (push_en && (wr_ptr_q == PW'(gi))) mem_q[gi] <= push_data_i;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding imem request FSM feeding a
// small fetch queue towards decode, with predictor and redirect hooks.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic        ck_i,
  input  logic        rs_i,
  ifu_fetch_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;
  logic            tag_taken_q, tag_taken_d;

  logic            imem_req;
  logic            fire;
  logic            fq_push;
  logic            fq_pop;
  logic            fq_full;
  logic            fq_empty;
  fq_entry_t       fq_push_entry;
  fq_entry_t       fq_head;

  // Reset gating keeps the request low while rs_i is held.
  assign imem_req = (state_q == ST_REQ) & ~bus.stall_i & ~bus.redirect_i
                  & ~fq_full & ~rs_i;
  assign fire     = imem_req & bus.imem_gnt_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tag_pc_d    = tag_pc_q;
    tag_taken_d = tag_taken_q;
    fq_push     = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (fire) begin
          state_d     = ST_WAIT;
          tag_pc_d    = pc_q;
          tag_taken_d = bus.bp_next_taken_i;
          pc_d        = bus.bp_next_pc_i;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_i) begin
          state_d = bus.imem_rvalid_i ? ST_REQ : ST_DROP;
        end else if (bus.imem_rvalid_i) begin
          fq_push = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        // A response arriving here always retires the stale request.
        if (bus.imem_rvalid_i) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
    if (bus.redirect_i) pc_d = bus.redirect_pc_i;
  end

  always_ff @(posedge ck_i or posedge rs_i) begin
    if (rs_i) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      tag_pc_q    <= '0;
      tag_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tag_pc_q    <= tag_pc_d;
      tag_taken_q <= tag_taken_d;
    end
  end

  assign fq_pop        = ~fq_empty & bus.id_ready_i;
  assign fq_push_entry = '{pc: tag_pc_q, ins: bus.imem_rdata_i, taken: tag_taken_q};

  ifu_fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (FQ_ENTRY_W)
  ) u_fifo (
    .ck_i        (ck_i),
    .rs_i        (rs_i),
    .push_i      (fq_push),
    .pop_i       (fq_pop),
    .clear_i     (bus.redirect_i),
    .push_data_i (fq_push_entry),
    .full_o      (fq_full),
    .empty_o     (fq_empty),
    .head_data_o (fq_head)
  );

  assign bus.bp_pc_o         = pc_q;
  assign bus.bp_stall_o      = ~fire;
  assign bus.imem_req_o      = imem_req;
  assign bus.imem_addr_o     = word_align(pc_q);
  assign bus.id_valid_o      = ~fq_empty;
  assign bus.id_pc_o         = fq_head.pc;
  assign bus.id_ins_o        = fq_head.ins;
  assign bus.id_pred_taken_o = fq_head.taken;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios then random traffic,
// every cycle compared against a transaction-level fetch model.
module tb_ifu_fetch;

  localparam int unsigned     DEPTH  = 2;
  localparam logic [31:0]     RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        taken;
  } ent_t;

  logic ck;
  logic rs;
  ifu_fetch_if bus ();

  ifu_fetch #(
    .RESET_PC (RST_PC),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .ck_i (ck),
    .rs_i (rs),
    .bus  (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Model: next PC, one outstanding request (possibly to be dropped), queue.
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_drop;
  logic [31:0] m_tpc;
  logic        m_ttaken;
  ent_t        m_q[$];

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_busy   = 1'b0;
    m_drop   = 1'b0;
    m_tpc    = '0;
    m_ttaken = 1'b0;
    m_q.delete();
  endtask

  function automatic logic exp_req();
    return !m_busy && !bus.stall_i && !bus.redirect_i && (m_q.size() < DEPTH);
  endfunction

  task automatic check_cycle();
    ent_t h;
    logic er;
    er = exp_req();
    h  = (m_q.size() > 0) ? m_q[0] : '0;
    chk("imem_req",   32'(bus.imem_req_o),      32'(er));
    chk("imem_addr",  bus.imem_addr_o,          m_pc & 32'hFFFF_FFFC);
    chk("bp_pc",      bus.bp_pc_o,              m_pc);
    chk("bp_stall",   32'(bus.bp_stall_o),      32'(!(er && bus.imem_gnt_i)));
    chk("id_valid",   32'(bus.id_valid_o),      32'(m_q.size() > 0));
    chk("id_pc",      bus.id_pc_o,              h.pc);
    chk("id_ins",     bus.id_ins_o,             h.ins);
    chk("id_taken",   32'(bus.id_pred_taken_o), 32'(h.taken));
  endtask

  task automatic model_step();
    logic er;
    logic fire;
    logic pop;
    ent_t e;
    er   = exp_req();
    fire = er && bus.imem_gnt_i;
    pop  = (m_q.size() > 0) && bus.id_ready_i;
    if (bus.redirect_i) begin
      m_q.delete();
      m_pc = bus.redirect_pc_i;
      if (m_busy) begin
        if (bus.imem_rvalid_i) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      if (pop) begin
        e = m_q.pop_front();
        $display("decode pc=%h ins=%h taken=%0d", e.pc, e.ins, e.taken);
      end
      if (m_busy && bus.imem_rvalid_i) begin
        if (!m_drop) begin
          e.pc    = m_tpc;
          e.ins   = bus.imem_rdata_i;
          e.taken = m_ttaken;
          m_q.push_back(e);
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
      if (fire) begin
        m_busy   = 1'b1;
        m_tpc    = m_pc;
        m_ttaken = bus.bp_next_taken_i;
        m_pc     = bus.bp_next_pc_i;
      end
    end
  endtask

  // Called just after a rising edge: check mid-cycle, advance model, next edge.
  task automatic cycle();
    #4;
    check_cycle();
    model_step();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input logic gnt, input logic rvalid, input logic ready,
                       input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic [31:0] npc, input logic taken, input logic [31:0] rdata);
    bus.imem_gnt_i      = gnt;
    bus.imem_rvalid_i   = rvalid;
    bus.id_ready_i      = ready;
    bus.stall_i         = stall;
    bus.redirect_i      = redir;
    bus.redirect_pc_i   = rpc;
    bus.bp_next_pc_i    = npc;
    bus.bp_next_taken_i = taken;
    bus.imem_rdata_i    = rdata;
  endtask

  task automatic do_reset(input int n);
    rs = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      #3;
      chk("rst_req",   32'(bus.imem_req_o), 32'd0);
      chk("rst_valid", 32'(bus.id_valid_o), 32'd0);
      chk("rst_bp_pc", bus.bp_pc_o,         RST_PC);
      chk("rst_id_pc", bus.id_pc_o,         32'd0);
      chk("rst_ins",   bus.id_ins_o,        32'd0);
      @(posedge ck);
      #1;
    end
    rs = 1'b0;
  endtask

  // Memory model responding one cycle after grant, predictor returning pc+4.
  task automatic stream(input int n, input logic ready, input logic [31:0] tk_pc,
                        input logic [31:0] tk_tgt);
    logic tk;
    for (int i = 0; i < n; i++) begin
      tk = (m_pc == tk_pc);
      drive(1'b1, m_busy, ready, 1'b0, 1'b0, 32'd0,
            tk ? tk_tgt : m_pc + 32'd4, tk, 32'hA500_0000 ^ m_pc);
      cycle();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rs          = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    model_reset();
    #1;
    do_reset(3);
    chk("first_addr", bus.imem_addr_o, RST_PC);

    // Sequential stream with a predicted-taken branch at 0x8 -> 0x100.
    stream(12, 1'b1, 32'h8, 32'h100);

    // Redirect while a response is pending.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, m_pc + 32'd4, 1'b0, 32'h1111_1111);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'd0, 1'b0, 32'h2222_2222);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h3333_3333);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    #4;
    chk("redir_addr",  bus.imem_addr_o,      32'h200);
    chk("redir_empty", 32'(bus.id_valid_o),  32'd0);
    model_step();
    @(posedge ck);
    #1;

    // Backpressure fills the queue, then release.
    stream(10, 1'b0, 32'hFFFF_FFFF, 32'd0);
    #4;
    chk("bp_full_req",   32'(bus.imem_req_o), 32'd0);
    chk("bp_full_stall", 32'(bus.bp_stall_o), 32'd1);
    model_step();
    @(posedge ck);
    #1;
    stream(8, 1'b1, 32'hFFFF_FFFF, 32'd0);

    // Stall with one response pending.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, m_pc + 32'd4, 1'b0, 32'd0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 1), 1'b0, 1'b1, 1'b0, 32'd0, m_pc + 32'd64, 1'b1, 32'hC0DE_0000 + i);
      cycle();
    end
    stream(4, 1'b1, 32'hFFFF_FFFF, 32'd0);

    // Reset while waiting; the late response must be ignored.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, m_pc + 32'd4, 1'b0, 32'd0);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    do_reset(2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'hDEAD_BEEF);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    #4;
    chk("late_rvalid", 32'(bus.id_valid_o), 32'd0);
    chk("late_addr",   bus.imem_addr_o,     RST_PC);
    model_step();
    @(posedge ck);
    #1;

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1);
      end
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 1),
            ($urandom_range(0, 19) == 0), $urandom,
            ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4,
            ($urandom_range(0, 3) == 0), $urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter FQ_DEPTH, default 2, SHALL be the fetch-queue depth (power of two, >=2).
REQ-003 ck_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rs_i  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 bp_pc_o  out  32  SHALL carry the current fetch PC to the branch predictor.
REQ-006 bp_stall_o  out  1  SHALL be high in every cycle the fetch PC does not advance.
REQ-007 bp_next_pc_i  in  32  SHALL carry the predicted next PC for bp_pc_o.
REQ-008 bp_next_taken_i  in  1  SHALL carry the predicted-taken flag for bp_pc_o.
REQ-009 redirect_i  in  1  SHALL carry the EX mispredict/redirect strobe.
REQ-010 redirect_pc_i  in  32  SHALL carry the corrected PC.
REQ-011 stall_i  in  1  SHALL carry the pipeline-control fetch hold.
REQ-012 imem_req_o  out  1  SHALL be the instruction memory request valid.
REQ-013 imem_addr_o  out  32  SHALL be the request address.
REQ-014 imem_gnt_i  in  1  SHALL be the request accept.
REQ-015 imem_rvalid_i  in  1  SHALL be the response valid.
REQ-016 imem_rdata_i  in  32  SHALL be the response instruction.
REQ-017 id_valid_o  out  1  SHALL be high when the decode entry is valid.
REQ-018 id_pc_o  out  32  SHALL be the PC of the decode entry.
REQ-019 id_ins_o  out  32  SHALL be the instruction of the decode entry.
REQ-020 id_pred_taken_o  out  1  SHALL be the predicted-taken flag of the decode entry.
REQ-021 id_ready_i  in  1  SHALL be high when decode accepts the entry.

Function
REQ-022 FSM states SHALL be REQ, WAIT and DROP; the reset state SHALL be REQ; at most one memory request SHALL be outstanding.
REQ-023 In REQ, imem_req_o SHALL equal ~stall_i & ~redirect_i & (fq_count < FQ_DEPTH).
REQ-024 imem_addr_o SHALL be {pc_r[31:2],2'b00}, and bp_pc_o SHALL be pc_r.
REQ-025 On imem_req_o & imem_gnt_i: latch pc_r and bp_next_taken_i as in-flight tags, load pc_r <= bp_next_pc_i, go to WAIT.
REQ-026 bp_stall_o SHALL equal ~(imem_req_o & imem_gnt_i).
REQ-027 In WAIT, on imem_rvalid_i without redirect_i: push {tag pc, imem_rdata_i, tag taken} into the queue and go to REQ; space is guaranteed by REQ-023.
REQ-028 A redirect_i in any state SHALL load pc_r <= redirect_pc_i and clear the queue (count 0) in the same edge, overriding any pop.
REQ-029 A redirect_i in WAIT without imem_rvalid_i SHALL go to DROP; with imem_rvalid_i in the same cycle, the response SHALL be discarded and the FSM SHALL go to REQ.
REQ-030 In DROP, imem_rvalid_i SHALL be discarded and the FSM SHALL go to REQ; redirect_i in DROP SHALL update pc_r and keep the FSM in DROP.
REQ-031 The queue SHALL pop on id_valid_o & id_ready_i; a simultaneous push and pop SHALL keep the count unchanged; the pointers SHALL wrap modulo FQ_DEPTH.
REQ-032 id_* outputs SHALL present the queue head; when the queue is empty, id_valid_o and all id data SHALL be 0.
REQ-033 stall_i SHALL only mask new requests; responses and pops SHALL continue during stall_i.
REQ-034 Grant-to-decode latency SHALL be the response latency; with no empty-queue bypass, an entry pushed at edge N SHALL be visible from cycle N+1.
REQ-035 PC arithmetic SHALL be 32-bit, wrapping, with no overflow detection.

Reset
REQ-036 While rs_i is high: pc_r=RESET_PC, state=REQ, queue count and pointers 0, tags 0, and imem_req_o, id_valid_o and all id data 0.
REQ-037 Assertion of rs_i mid-transaction SHALL abandon it; a late imem_rvalid_i arriving in REQ after reset SHALL be ignored.

Structure
REQ-038 RESET_PC default, the FSM state encoding and the 32-bit instruction/address widths SHALL live in the shared core defines package.
REQ-039 The queue SHALL be the sub-module ifu_fetch_fifo (push, pop, clear, full, empty, head data).

Verification
REQ-040 Reset and stream: rs_i pulse, gnt=1, rvalid one cycle after gnt, predictor returns pc+4 -> id_pc 0,4,8 in order, one entry per 2 cycles.
REQ-041 Predicted taken: bp_next_pc_i=0x100, taken=1 for pc 0x8 -> next imem_addr 0x100, entry 0x8 carries id_pred_taken_o=1.
REQ-042 Redirect in WAIT: redirect_pc_i=0x200 before rvalid -> DROP, stale response not pushed, next request address 0x200, queue empty.
REQ-043 Backpressure: id_ready_i=0 -> exactly FQ_DEPTH entries queued, imem_req_o=0, bp_stall_o=1; id_ready_i=1 resumes fetch.
REQ-044 stall_i=1 for 5 cycles with one response pending -> response still pushed, no new request, pc_r held.
REQ-045 rs_i asserted in WAIT, rvalid arrives after release -> no entry pushed, first request address RESET_PC.
